// File: rtl/ising_dsp_pkg.sv
// Shared widths, calibrator state encoding and marker-word construction
// for the DAC/ADC word-stream blocks.
package ising_dsp_pkg;

   localparam int SAMPLE_W         = 16;
   localparam int SAMPLES_PER_WORD = 16;
   localparam int WORD_W           = SAMPLE_W * SAMPLES_PER_WORD;

   typedef enum logic [2:0] {
      IDLE,
      QUIET,
      SEND,
      WAIT,
      DONE,
      TOUT
   } cal_state_t;

   // Marker sits in sample 0 so it is the earliest sample of its word.
   function automatic logic [WORD_W-1:0] marker_word(input logic signed [SAMPLE_W-1:0] amp);
      logic [WORD_W-1:0] w;
      w = '0;
      w[SAMPLE_W-1:0] = amp;
      return w;
   endfunction

endpackage

// File: rtl/first_crossing_encoder.sv
// Combinational search for the earliest sample of a word whose signed
// value is strictly above a threshold.
module first_crossing_encoder
   import ising_dsp_pkg::*;
(
   input  logic [WORD_W-1:0]          word,
   input  logic signed [SAMPLE_W-1:0] threshold,
   output logic                       hit,
   output logic [3:0]                 idx
);

   // Scan from the latest sample down so the lowest crossing index wins.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = SAMPLES_PER_WORD - 1; i >= 0; i--) begin
         if ($signed(word[i*SAMPLE_W +: SAMPLE_W]) > threshold) begin
            hit = 1'b1;
            idx = 4'(i);
         end
      end
   end

endmodule

// File: rtl/loop_delay_calibrator.sv
// Injects a one-sample marker into the DAC stream and measures, in samples,
// how long it takes to return on the ADC stream.
module loop_delay_calibrator
   import ising_dsp_pkg::*;
#(
   parameter int                         QUIET_CYCLES    = 32,
   parameter int                         MAX_WAIT_CYCLES = 16,
   parameter logic signed [SAMPLE_W-1:0] MARKER_AMP      = 16'sh4000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic signed [SAMPLE_W-1:0] threshold,
   input  logic [WORD_W-1:0]          dac_word_in,
   output logic [WORD_W-1:0]          dac_word_out,
   input  logic [WORD_W-1:0]          adc_word_in,
   output logic [7:0]                 delay_samples,
   output logic                       busy,
   output logic                       done,
   output logic                       timeout,
   output cal_state_t                 dbg_state
);

   localparam int CNT_W = (QUIET_CYCLES > MAX_WAIT_CYCLES) ? $clog2(QUIET_CYCLES)
                                                           : $clog2(MAX_WAIT_CYCLES);

   cal_state_t                 state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic signed [SAMPLE_W-1:0] thr_q, thr_d;
   logic [7:0]                 delay_d;
   logic [WORD_W-1:0]          dac_mux;
   logic                       hit;
   logic [3:0]                 idx;

   first_crossing_encoder u_enc (
      .word      (adc_word_in),
      .threshold (thr_q),
      .hit       (hit),
      .idx       (idx)
   );

   // start is a bare one-cycle request: accepted only in IDLE, otherwise
   // dropped with no side effect; there is no ready/acknowledge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      thr_d   = thr_q;
      delay_d = delay_samples;
      dac_mux = '0;
      unique case (state_q)
         IDLE: begin
            dac_mux = dac_word_in;
            if (start) begin
               thr_d   = threshold;
               cnt_d   = '0;
               state_d = QUIET;
            end
         end
         QUIET: begin
            if (cnt_q == CNT_W'(QUIET_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = SEND;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SEND: begin
            dac_mux = marker_word(MARKER_AMP);
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // Detection outranks timeout on the last examined word.
            if (hit) begin
               delay_d = {cnt_q[3:0], idx};
               state_d = DONE;
            end else if (cnt_q == CNT_W'(MAX_WAIT_CYCLES - 1)) begin
               state_d = TOUT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         TOUT:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         thr_q         <= '0;
         delay_samples <= '0;
         dac_word_out  <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         thr_q         <= thr_d;
         delay_samples <= delay_d;
         dac_word_out  <= dac_mux;
      end
   end

   assign busy      = (state_q == QUIET) || (state_q == SEND) || (state_q == WAIT);
   assign done      = (state_q == DONE);
   assign timeout   = (state_q == TOUT);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_loop_delay_calibrator.sv
// Directed bench: a behavioural sample-delay loop feeds the DAC output back
// to the ADC input, and each measurement is checked against hand values.
module tb_loop_delay_calibrator;
   import ising_dsp_pkg::*;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               start = 1'b0;
   logic signed [15:0] threshold = '0;
   logic [255:0]       dac_word_in = '0;
   logic [255:0]       dac_word_out;
   logic [255:0]       adc_word_in = '0;
   logic [7:0]         delay_samples;
   logic               busy, done, timeout;
   cal_state_t         dbg_state;

   int           n_checks = 0;
   int           n_errors = 0;
   logic [255:0] hw [0:16];
   int           loop_delay = 0;
   bit           loop_on = 1'b1;

   localparam logic [255:0] BUSY_PAT = {16{16'h7000}};

   always #5 clk = ~clk;

   loop_delay_calibrator dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .threshold     (threshold),
      .dac_word_in   (dac_word_in),
      .dac_word_out  (dac_word_out),
      .adc_word_in   (adc_word_in),
      .delay_samples (delay_samples),
      .busy          (busy),
      .done          (done),
      .timeout       (timeout),
      .dbg_state     (dbg_state)
   );

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ADC sample j of the current word = DAC sample (16*now + j - loop_delay).
   function automatic logic [255:0] loop_word();
      logic [255:0] r;
      r = '0;
      for (int j = 0; j < 16; j++) begin
         int n;
         int wb;
         n  = j - loop_delay;
         wb = 0;
         while (n < 0) begin
            n += 16;
            wb++;
         end
         r[j*16 +: 16] = hw[wb][n*16 +: 16];
      end
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      for (int w = 16; w > 0; w--) hw[w] = hw[w-1];
      hw[0] = dac_word_out;
      if (loop_on) adc_word_in = loop_word();
   endtask

   task automatic measure(input string tag, input logic signed [15:0] thr, input int d,
                          input bit custom, input int custom_k, input logic [255:0] custom_w,
                          input bit retrig, input bit exp_done, input logic [7:0] exp_delay);
      int m;
      bit ended;
      loop_delay  = d;
      loop_on     = !custom;
      if (custom) adc_word_in = '0;
      dac_word_in = BUSY_PAT;
      threshold   = thr;
      start       = 1'b1;
      step();
      start     = 1'b0;
      threshold = 16'sh7fff;
      check({tag, " busy_after_start"}, busy, 1);
      m = 0;
      ended = 1'b0;
      while (!ended && m < 60) begin
         if (retrig && m == 5) start = 1'b1;
         step();
         m++;
         start = 1'b0;
         if (custom) adc_word_in = (m == 33 + custom_k) ? custom_w : '0;
         if (m == 10) check({tag, " quiet_zero"}, dac_word_out, '0);
         if (m == 33) check({tag, " marker"}, dac_word_out, marker_word(16'sh4000));
         if (done || timeout) ended = 1'b1;
      end
      check({tag, " done"}, done, exp_done);
      check({tag, " timeout"}, timeout, !exp_done);
      check({tag, " busy_at_end"}, busy, 0);
      check({tag, " cycles"}, m, exp_done ? 34 + int'(exp_delay[7:4]) : 49);
      check({tag, " delay"}, delay_samples, exp_delay);
      if (retrig) start = 1'b1;
      step();
      start = 1'b0;
      check({tag, " pulse_single"}, {done, timeout}, 2'b00);
      step();
      check({tag, " idle_after"}, busy, 0);
      check({tag, " passthrough"}, dac_word_out, BUSY_PAT);
   endtask

   initial begin
      logic [255:0] multi_w;
      logic [255:0] pat;
      for (int w = 0; w <= 16; w++) hw[w] = '0;

      #3;
      check("reset dac_word_out", dac_word_out, '0);
      check("reset delay", delay_samples, '0);
      check("reset flags", {busy, done, timeout}, 3'b000);
      #9 rst = 1'b1;

      measure("d37", 16'sh1000, 37, 1'b0, 0, '0, 1'b0, 1'b1, 8'd37);
      measure("d0", 16'sh1000, 0, 1'b0, 0, '0, 1'b0, 1'b1, 8'd0);
      measure("d255", 16'sh1000, 255, 1'b0, 0, '0, 1'b0, 1'b1, 8'd255);

      multi_w = '0;
      multi_w[2*16 +: 16]  = 16'h9000;
      multi_w[6*16 +: 16]  = 16'h1000;
      multi_w[7*16 +: 16]  = 16'h2000;
      multi_w[8*16 +: 16]  = 16'h2000;
      multi_w[9*16 +: 16]  = 16'h2000;
      measure("multi", 16'sh1000, 0, 1'b1, 3, multi_w, 1'b0, 1'b1, 8'd55);

      measure("strict", 16'sh4000, 10, 1'b0, 0, '0, 1'b0, 1'b0, 8'd55);
      measure("retrig", 16'sh1000, 20, 1'b0, 0, '0, 1'b1, 1'b1, 8'd20);
      measure("second", 16'sh3fff, 100, 1'b0, 0, '0, 1'b0, 1'b1, 8'd100);

      loop_delay  = 255;
      loop_on     = 1'b1;
      threshold   = 16'sh1000;
      start       = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 40; i++) step();
      check("midwait busy", busy, 1);
      #2 rst = 1'b0;
      #1;
      check("abort dac_word_out", dac_word_out, '0);
      check("abort delay", delay_samples, '0);
      check("abort flags", {busy, done, timeout}, 3'b000);
      step();
      step();
      check("abort no_pulse", {busy, done, timeout}, 3'b000);
      rst = 1'b1;
      pat = {16{16'h1234}};
      dac_word_in = pat;
      step();
      check("release passthrough", dac_word_out, pat);
      check("release flags", {busy, done, timeout}, 3'b000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
